cla_subtractor16_seq: RTL and testbench
=======================================

Name: cla_subtractor16_seq

Overview:
- Multi-cycle, handshaked subtractor; the companion of the carry-lookahead adder.
- Computes a - b as a + ~b + 1, one GROUP-bit lookahead slice per cycle, starting with carry-in 1.
- Sits between an operand producer and a result consumer, with valid/ready on both sides.
- Gives an exact reference path that the approximate adder/subtractor variants are compared against.

Parameters:
- width, 16, operand width in bits.
- group, 4, bits resolved per cycle. width must be a multiple of group; the block fails elaboration otherwise.

Ports:
- clk_i  input  1  clock; everything is on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- valid_i  input  1  operands present on minuend_i/subtrahend_i.
- ready_o  output  1  block can accept operands.
- minuend_i  input  width  operand a.
- subtrahend_i  input  width  operand b.
- valid_o  output  1  result_o/borrow_o/overflow_o are valid.
- ready_i  input  1  consumer accepts the result.
- result_o  output  width+1  {carry_out, difference}. carry_out=1 means no borrow.
- borrow_o  output  1  ~carry_out, i.e. unsigned a<b.
- overflow_o  output  1  signed overflow: a[msb]!=b[msb] and diff[msb]!=a[msb].

Behaviour:
- Reset: state IDLE, ready_o=1, valid_o=0, result_o=0, borrow_o=0, overflow_o=0, internal carry=1, group index=0. Reset takes priority over every other event.
- FSM states: IDLE, CALC, DONE.
  - IDLE: ready_o=1. On valid_i&&ready_o, capture a and ~b, set carry=1 and idx=0, clear the difference register, go to CALC.
  - CALC: ready_o=0, valid_o=0.
    - Each cycle, compute slice idx: g=a&~b, p=a|~b, lookahead carries from g/p and carry, sum bits = a^~b^c.
    - Write the slice into difference[idx*group +: group], update carry to the slice carry-out, increment idx.
    - On the last slice (idx=width/group-1), go to DONE.
  - DONE: valid_o=1; outputs are registered and held stable. On valid_o&&ready_i, go to IDLE, so ready_o=1 on the next cycle.
- Latency: valid_o rises width/group cycles after the accept edge (4 for the defaults).
- Throughput: one operation per width/group+2 cycles. No accept in the same cycle as a result handoff.
- valid_i while busy (CALC or DONE) is ignored. Operands change only after capture; the captured copy is used.
- Backpressure: ready_i low in DONE holds all outputs indefinitely.
- Reset mid-CALC or mid-DONE aborts the operation: no valid_o is issued and the outputs return to reset values.
- Arithmetic is modulo 2^width. carry_out equals the final slice carry. overflow_o is computed from the captured operand msbs and the final difference msb, registered with the result.
- a==b gives difference 0, carry_out=1, borrow_o=0.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/CALC/DONE).
  - Default width and group constants.
  - Slice-count constant width/group.
  - Index width clog2(width/group).
- One combinational sub-module, cla_group: group-bit generate/propagate lookahead slice.
  - Inputs: a_slice, b_slice_inverted, carry_in.
  - Outputs: sum_slice, carry_out, group_generate, group_propagate.
  - One instance is reused each cycle through a mux driven by idx.

Test Plan:
- Basic: 0x1234-0x0234 → after 4 cycles valid_o=1, result_o=0x11000, borrow_o=0, overflow_o=0.
- Underflow: 0x0000-0x0001 → result_o=0x0FFFF, borrow_o=1, overflow_o=0.
- Signed overflow: 0x8000-0x0001 → result_o=0x17FFF, borrow_o=0, overflow_o=1. Then 0x7FFF-0xFFFF → result_o=0x08000, borrow_o=1, overflow_o=1.
- Backpressure and busy: hold ready_i=0 for 5 cycles in DONE → outputs stable, ready_o=0. Toggle valid_i with new operands during CALC → ignored; the next accepted op is only after the handoff.
- Reset mid-op: assert rst_i in the 2nd CALC cycle → next cycle ready_o=1, valid_o=0, result_o=0. A fresh 0xFFFF-0xFFFF then yields result_o=0x10000.
- Random: 1000 random pairs with random ready_i → every result_o equals {a>=b, (a-b) mod 2^16}, latency exactly 4 cycles from accept.

Source files
------------

// File: rtl/cla_subtractor16_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla_subtractor16_seq_pkg
// Purpose  : Shared FSM encoding and sizing constants for the sequential
//            carry-lookahead subtractor.
// Revision : 1.0
// ============================================================================
package cla_subtractor16_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int c_default_width  = 16;
    localparam int c_default_group  = 4;
    localparam int c_default_slices = c_default_width / c_default_group;

    // A single-slice configuration still needs a 1-bit index register.
    function automatic int idx_width(input int slices);
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction

    localparam int c_default_idx_w = idx_width(c_default_slices);

endpackage
`default_nettype wire

// File: rtl/cla_subtractor16_seq_cla_group.sv
`default_nettype none
// ============================================================================
// Module   : cla_group
// Purpose  : GROUP-bit generate/propagate lookahead slice (combinational).
// Revision : 1.0
// ============================================================================
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] i_a_slice,
    input  logic [GROUP-1:0] i_b_slice_inverted,
    input  logic             i_carry_in,
    output logic [GROUP-1:0] o_sum_slice,
    output logic             o_carry_out,
    output logic             o_group_generate,
    output logic             o_group_propagate
);

    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_p;
    logic [GROUP:0]   w_c;
    logic             w_ptmp;
    logic             w_gen;

    assign w_g = i_a_slice & i_b_slice_inverted;
    assign w_p = i_a_slice | i_b_slice_inverted;

    // Every carry is expanded as a flat sum of g/p products, not a ripple chain.
    always_comb begin
        w_c    = '0;
        w_ptmp = 1'b0;
        w_c[0] = i_carry_in;
        for (int i = 0; i < GROUP; i++) begin
            w_c[i+1] = w_g[i];
            w_ptmp   = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_c[i+1] = w_c[i+1] | (w_ptmp & w_g[j]);
                w_ptmp   = w_ptmp & w_p[j];
            end
            w_c[i+1] = w_c[i+1] | (w_ptmp & i_carry_in);
        end
    end

    always_comb begin
        w_gen = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            w_gen = w_g[i] | (w_p[i] & w_gen);
        end
    end

    assign o_sum_slice       = i_a_slice ^ i_b_slice_inverted ^ w_c[GROUP-1:0];
    assign o_carry_out       = w_c[GROUP];
    assign o_group_generate  = w_gen;
    assign o_group_propagate = &w_p;

endmodule
`default_nettype wire

// File: rtl/cla_subtractor16_seq.sv
`default_nettype none
// ============================================================================
// Module   : cla_subtractor16_seq
// Purpose  : Handshaked multi-cycle subtractor, a + ~b + 1, one lookahead
//            slice per cycle. Exact reference for the approximate variants.
// Revision : 1.0
// ============================================================================
module cla_subtractor16_seq
    import cla_subtractor16_seq_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int GROUP = c_default_group
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] minuend_i,
    input  logic [WIDTH-1:0] subtrahend_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH:0]   result_o,
    output logic             borrow_o,
    output logic             overflow_o
);

    localparam int                 c_slices = WIDTH / GROUP;
    localparam int                 c_idx_w  = idx_width(c_slices);
    localparam logic [c_idx_w-1:0] c_last   = c_idx_w'(c_slices - 1);

    generate
        if ((WIDTH % GROUP) != 0 || GROUP < 1) begin : g_param_check
            $error("cla_subtractor16_seq: WIDTH must be a positive multiple of GROUP");
        end
    endgenerate

    state_e             state_q,    state_d;
    logic [WIDTH-1:0]   a_q,        a_d;
    logic [WIDTH-1:0]   bn_q,       bn_d;
    logic [WIDTH-1:0]   diff_q,     diff_d;
    logic               carry_q,    carry_d;
    logic [c_idx_w-1:0] idx_q,      idx_d;
    logic [WIDTH:0]     result_q,   result_d;
    logic               borrow_q,   borrow_d;
    logic               overflow_q, overflow_d;

    logic [GROUP-1:0]   w_a_slices  [c_slices];
    logic [GROUP-1:0]   w_bn_slices [c_slices];
    logic [GROUP-1:0]   w_sum_slice;
    logic               w_slice_carry;
    logic               w_group_generate;
    logic               w_group_propagate;
    logic               w_unused_gp;

    generate
        for (genvar s = 0; s < c_slices; s++) begin : g_slices
            assign w_a_slices[s]  = a_q[s*GROUP +: GROUP];
            assign w_bn_slices[s] = bn_q[s*GROUP +: GROUP];
        end
    endgenerate

    // One slice instance, time-shared across the operand via idx_q.
    cla_group #(
        .GROUP (GROUP)
    ) u_cla_group (
        .i_a_slice          (w_a_slices[idx_q]),
        .i_b_slice_inverted (w_bn_slices[idx_q]),
        .i_carry_in         (carry_q),
        .o_sum_slice        (w_sum_slice),
        .o_carry_out        (w_slice_carry),
        .o_group_generate   (w_group_generate),
        .o_group_propagate  (w_group_propagate)
    );

    // Group G/P are exported for a future multi-level tree; unused here.
    assign w_unused_gp = w_group_generate ^ w_group_propagate;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        bn_d       = bn_q;
        diff_d     = diff_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        result_d   = result_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;
        ready_o    = 1'b0;
        valid_o    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    a_d     = minuend_i;
                    bn_d    = ~subtrahend_i;
                    carry_d = 1'b1;
                    idx_d   = '0;
                    diff_d  = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                for (int s = 0; s < c_slices; s++) begin
                    if (idx_q == c_idx_w'(s)) begin
                        diff_d[s*GROUP +: GROUP] = w_sum_slice;
                    end
                end
                carry_d = w_slice_carry;
                idx_d   = idx_q + c_idx_w'(1);
                if (idx_q == c_last) begin
                    idx_d      = '0;
                    result_d   = {w_slice_carry, diff_d};
                    borrow_d   = ~w_slice_carry;
                    // bn_q holds ~b, so its msb is the inverse of b's sign.
                    overflow_d = (a_q[WIDTH-1] == bn_q[WIDTH-1]) &&
                                 (diff_d[WIDTH-1] != a_q[WIDTH-1]);
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            bn_q       <= '0;
            diff_q     <= '0;
            carry_q    <= 1'b1;
            idx_q      <= '0;
            result_q   <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            bn_q       <= bn_d;
            diff_q     <= diff_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            result_q   <= result_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
        end
    end

    assign result_o   = result_q;
    assign borrow_o   = borrow_q;
    assign overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_subtractor16_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_subtractor16_seq
// Purpose  : Scoreboard bench for cla_subtractor16_seq (directed + random).
// Revision : 1.0
// ============================================================================
module tb_cla_subtractor16_seq;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] minuend_i;
    logic [15:0] subtrahend_i;
    logic        valid_o;
    logic        ready_i;
    logic [16:0] result_o;
    logic        borrow_o;
    logic        overflow_o;

    cla_subtractor16_seq #(
        .WIDTH (16),
        .GROUP (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .minuend_i    (minuend_i),
        .subtrahend_i (subtrahend_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .result_o     (result_o),
        .borrow_o     (borrow_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] res;
        logic        bor;
        logic        ov;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    logic rand_ready  = 1'b0;
    logic ready_force = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Consumer ready: random or forced, updated just after each rising edge.
    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            ready_i = rand_ready ? ($urandom_range(0, 1) != 0) : ready_force;
        end
    end

    // Monitor: latency on each valid rise, result check on each handoff.
    initial begin
        exp_t e;
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (valid_o && !prev_v) begin
                    if (sb.size() == 0) fail_now("unexpected_valid");
                    else chk("latency", cyc - sb[0].acc, 4);
                end
                if (valid_o && ready_i) begin
                    if (sb.size() == 0) begin
                        fail_now("handoff_without_expected");
                    end else begin
                        e = sb.pop_front();
                        chk("result", 32'(result_o), 32'(e.res));
                        chk("borrow", 32'(borrow_o), 32'(e.bor));
                        chk("overflow", 32'(overflow_o), 32'(e.ov));
                    end
                end
            end
            prev_v = rst_i ? 1'b0 : valid_o;
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [16:0] res, input logic bor, input logic ov);
        exp_t e;
        bit   done;
        done         = 1'b0;
        valid_i      = 1'b1;
        minuend_i    = a;
        subtrahend_i = b;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (ready_o) begin
                e.res = res;
                e.bor = bor;
                e.ov  = ov;
                e.acc = cyc + 1;
                sb.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) fail_now("accept_timeout");
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
        chk("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic stall_check;
        logic [16:0] r0;
        logic        b0, o0;
        bit          seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = valid_o;
        end
        if (!seen) begin
            fail_now("stall_valid_timeout");
        end else begin
            r0 = result_o;
            b0 = borrow_o;
            o0 = overflow_o;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("stall_valid", 32'(valid_o), 32'd1);
                chk("stall_ready_o", 32'(ready_o), 32'd0);
                chk("stall_result", 32'(result_o), 32'(r0));
                chk("stall_flags", {30'd0, borrow_o, overflow_o}, {30'd0, b0, o0});
            end
        end
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("after_handoff_ready", 32'(ready_o), 32'd1);
        chk("after_handoff_valid", 32'(valid_o), 32'd0);
    endtask

    // Directed vectors: {a, b, expected result, borrow, overflow}
    logic [15:0] dv_a   [8] = '{16'h1234, 16'h0000, 16'h8000, 16'h7FFF,
                                16'h0005, 16'h0000, 16'hFFFF, 16'h8000};
    logic [15:0] dv_b   [8] = '{16'h0234, 16'h0001, 16'h0001, 16'hFFFF,
                                16'h0003, 16'h0000, 16'h0000, 16'h7FFF};
    logic [16:0] dv_res [8] = '{17'h11000, 17'h0FFFF, 17'h17FFF, 17'h08000,
                                17'h10002, 17'h10000, 17'h1FFFF, 17'h10001};
    logic        dv_bor [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        dv_ov  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        logic [15:0] a, b, d;
        rst_i        = 1'b1;
        valid_i      = 1'b0;
        minuend_i    = '0;
        subtrahend_i = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_ready_o", 32'(ready_o), 32'd1);
        chk("reset_valid_o", 32'(valid_o), 32'd0);
        chk("reset_result", 32'(result_o), 32'd0);
        chk("reset_flags", {30'd0, borrow_o, overflow_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Directed vectors under random consumer backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue(dv_a[i], dv_b[i], dv_res[i], dv_bor[i], dv_ov[i]);
        end
        drain(300);

        // Busy/backpressure: second op held on valid_i throughout CALC and DONE.
        rand_ready  = 1'b0;
        ready_force = 1'b0;
        @(posedge clk);
        #1;
        issue(16'h00F0, 16'h000F, 17'h100E1, 1'b0, 1'b0);
        fork
            issue(16'hABCD, 16'h1234, 17'h19999, 1'b0, 1'b0);
            stall_check();
        join
        drain(100);

        // Reset in the 2nd CALC cycle aborts the op.
        issue(16'h5555, 16'h1111, 17'h14444, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("abort_ready_o", 32'(ready_o), 32'd1);
        chk("abort_valid_o", 32'(valid_o), 32'd0);
        chk("abort_result", 32'(result_o), 32'd0);
        @(posedge clk);
        #1;
        issue(16'hFFFF, 16'hFFFF, 17'h10000, 1'b0, 1'b0);
        drain(100);

        // Random pairs against a reference model.
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom());
            b = (i % 17 == 0) ? a : 16'($urandom());
            d = a - b;
            issue(a, b, {(a >= b), d}, (a < b),
                  (a[15] != b[15]) && (d[15] != a[15]));
        end
        drain(500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
